dds_cfg_sequencer: RTL

//  Sits between the SPI command decoder and the DDS core.
//  - Holds shadow copies of the frequency, amplitude and waveform registers.
//  - Applies pending writes atomically on the next DDS phase-accumulator wrap,

---
 rtl/dds_cfg_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dds_cfg_sequencer.sv
// dds_cfg_sequencer: shadow DDS config regs applied on phase wrap (or timeout), plus RD_DDS readback sequencer.
// Ports: clk/reset_n (async, active low); cmd_valid/cmd_ready/cmd_op/cmd_arg command handshake;
// tx_buffer_free/tx_wr_en/tx_wr_data SPI TX push; dds_phase_wrap in; dds_freq/dds_amp/dds_wave/dds_update out; busy.
// Optional: define DDS_STATUS_WORD_EN to append a status word (pend flags + apply count) to RD_DDS.
module dds_cfg_sequencer #(
  parameter int FREQ_W       = 24,
  parameter int AMP_W        = 16,
  parameter int WAVE_W       = 8,
  parameter int WRAP_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_op,
  input  logic [23:0]       cmd_arg,
  input  logic              tx_buffer_free,
  output logic              tx_wr_en,
  output logic [23:0]       tx_wr_data,
  input  logic              dds_phase_wrap,
  output logic [FREQ_W-1:0] dds_freq,
  output logic [AMP_W-1:0]  dds_amp,
  output logic [WAVE_W-1:0] dds_wave,
  output logic              dds_update,
  output logic              busy
);
`ifdef DDS_STATUS_WORD_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif
  localparam int CW = (WRAP_TIMEOUT > 1) ? $clog2(WRAP_TIMEOUT) : 1;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  state_t            r_state;
  logic              r_ready;
  logic [1:0]        r_idx;
  logic [23:0]       r_word [NW];
  logic              r_tx_en;
  logic [23:0]       r_tx_data;
  logic [FREQ_W-1:0] r_freq, r_sh_freq;
  logic [AMP_W-1:0]  r_amp, r_sh_amp;
  logic [WAVE_W-1:0] r_wave, r_sh_wave;
  logic              r_pend_f, r_pend_aw, r_upd;
  logic [CW-1:0]     r_cnt;
`ifdef DDS_STATUS_WORD_EN
  logic [15:0]       r_apply_cnt;
`endif
  logic w_acc, w_wr_f, w_wr_aw, w_rd, w_pend, w_apply;
  assign w_acc   = cmd_valid & r_ready;
  assign w_wr_f  = w_acc & (cmd_op == 8'd9);
  assign w_wr_aw = w_acc & (cmd_op == 8'd8);
  assign w_rd    = w_acc & (cmd_op == 8'd10);
  assign w_pend  = r_pend_f | r_pend_aw;
  // apply reads the pre-write shadow; a same-cycle write re-arms pend for the next wrap
  assign w_apply = w_pend & (dds_phase_wrap | (r_cnt == CW'(WRAP_TIMEOUT - 1)));
  assign cmd_ready  = r_ready;
  assign tx_wr_en   = r_tx_en;
  assign tx_wr_data = r_tx_data;
  assign dds_freq   = r_freq;
  assign dds_amp    = r_amp;
  assign dds_wave   = r_wave;
  assign dds_update = r_upd;
  assign busy       = (r_state != S_IDLE) | w_pend;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_freq    <= '0;
      r_amp     <= '0;
      r_wave    <= '0;
      r_sh_freq <= '0;
      r_sh_amp  <= '0;
      r_sh_wave <= '0;
      r_pend_f  <= 1'b0;
      r_pend_aw <= 1'b0;
      r_upd     <= 1'b0;
      r_cnt     <= '0;
`ifdef DDS_STATUS_WORD_EN
      r_apply_cnt <= '0;
`endif
    end else begin
      r_upd <= w_apply;
      if (w_apply && r_pend_f) r_freq <= r_sh_freq;
      if (w_apply && r_pend_aw) begin
        r_amp  <= r_sh_amp;
        r_wave <= r_sh_wave;
      end
      if (w_wr_f) r_sh_freq <= FREQ_W'(cmd_arg);
      if (w_wr_aw) begin
        r_sh_amp  <= AMP_W'(cmd_arg[15:0]);
        r_sh_wave <= WAVE_W'(cmd_arg[23:16]);
      end
      r_pend_f  <= w_wr_f | (r_pend_f & ~w_apply);
      r_pend_aw <= w_wr_aw | (r_pend_aw & ~w_apply);
      // counts only while something is pending, so later writes never restart it
      r_cnt <= (w_pend & ~w_apply) ? r_cnt + 1'b1 : '0;
`ifdef DDS_STATUS_WORD_EN
      r_apply_cnt <= r_apply_cnt + 16'(w_apply);
`endif
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_idx     <= '0;
      r_tx_en   <= 1'b0;
      r_tx_data <= '0;
      for (int i = 0; i < NW; i++) r_word[i] <= '0;
    end else begin
      r_tx_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_ready <= ~w_rd;
          if (w_rd) begin
            r_state   <= S_SEND;
            r_idx     <= '0;
            r_word[0] <= 24'(r_freq);
            r_word[1] <= 24'(r_wave);
            r_word[2] <= 24'(r_amp);
`ifdef DDS_STATUS_WORD_EN
            r_word[3] <= {r_pend_f, r_pend_aw, 6'b0, r_apply_cnt};
`endif
          end
        end
        S_SEND: if (tx_buffer_free) begin
          r_tx_en   <= 1'b1;
          r_tx_data <= r_word[r_idx];
          r_state   <= S_GAP;
        end
        S_GAP: begin
          r_state <= (r_idx == 2'(NW - 1)) ? S_IDLE : S_SEND;
          r_ready <= (r_idx == 2'(NW - 1));
          r_idx   <= r_idx + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
